// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller bundle: pipeline status into the controller, stall/flush
// controls and performance counters back out.
interface pipeline_hazard_controller_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             idex_memread;
   logic [4:0]       idex_write_reg;
   logic             exmem_branch_taken;
   logic             exmem_jump;
   logic             exmem_jr;
   logic             exmem_mem_access;
   logic             mem_ready;
   logic             pc_write;
   logic [1:0]       pc_src_sel;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_write;
   logic             idex_flush;
   logic             exmem_write;
   logic             exmem_flush;
   logic             memwb_bubble;
   logic             mem_error;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, idex_memread, idex_write_reg,
             exmem_branch_taken, exmem_jump, exmem_jr, exmem_mem_access, mem_ready,
      input  pc_write, pc_src_sel, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, memwb_bubble, mem_error, state,
             stall_count, flush_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, idex_memread, idex_write_reg,
             exmem_branch_taken, exmem_jump, exmem_jr, exmem_mem_access, mem_ready,
      output pc_write, pc_src_sel, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, memwb_bubble, mem_error, state,
             stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline (load-use, MEM redirects,
// data-memory waits). Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module pipeline_hazard_controller #(
   parameter int LU_BUBBLES  = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input logic clk,
   input logic reset,
   pipeline_hazard_controller_if.slave hz
);
   typedef enum logic [1:0] {
      RUN      = 2'b00,
      STALL_LU = 2'b01,
      MEM_WAIT = 2'b10,
      REDIRECT = 2'b11
   } state_t;

   localparam logic [1:0] BUB_LOAD = 2'(LU_BUBBLES - 1);
   localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);

   state_t     st_q, st_d;
   logic [1:0] bub_q, bub_d;
   logic [7:0] wait_q, wait_d;
   logic       err_q;
   logic       lu, rd, mw, tmo;

   assign lu  = hz.idex_memread && (hz.idex_write_reg != 5'd0) &&
                ((hz.id_rs == hz.idex_write_reg) ||
                 (hz.id_uses_rt && (hz.id_rt == hz.idex_write_reg)));
   assign rd  = hz.exmem_branch_taken | hz.exmem_jump | hz.exmem_jr;
   assign mw  = hz.exmem_mem_access & ~hz.mem_ready;
   // A timed-out wait is released exactly like a mem_ready cycle.
   assign tmo = mw && (wait_q == TMO);

   always_comb begin
      st_d            = RUN;
      bub_d           = bub_q;
      wait_d          = 8'd0;
      hz.pc_write     = 1'b1;
      hz.pc_src_sel   = 2'b00;
      hz.ifid_write   = 1'b1;
      hz.ifid_flush   = 1'b0;
      hz.idex_write   = 1'b1;
      hz.idex_flush   = 1'b0;
      hz.exmem_write  = 1'b1;
      hz.exmem_flush  = 1'b0;
      hz.memwb_bubble = 1'b0;
      if (!reset) begin
         bub_d = '0;
      end else if (mw && !tmo) begin
         st_d            = MEM_WAIT;
         wait_d          = wait_q + 8'd1;
         bub_d           = '0;
         hz.pc_write     = 1'b0;
         hz.ifid_write   = 1'b0;
         hz.idex_write   = 1'b0;
         hz.exmem_write  = 1'b0;
         hz.memwb_bubble = 1'b1;
      end else if (rd) begin
         st_d           = REDIRECT;
         bub_d          = '0;
         hz.ifid_flush  = 1'b1;
         hz.idex_flush  = 1'b1;
         hz.exmem_flush = 1'b1;
         hz.pc_src_sel  = hz.exmem_jr ? 2'b11 : hz.exmem_jump ? 2'b10 : 2'b01;
      end else if (st_q == STALL_LU && bub_q != 2'd0) begin
         // Remaining bubbles after the detection cycle.
         st_d          = STALL_LU;
         bub_d         = bub_q - 2'd1;
         hz.pc_write   = 1'b0;
         hz.ifid_write = 1'b0;
         hz.idex_flush = 1'b1;
      end else if (lu && st_q != REDIRECT) begin
         // ID holds the fresh fetch while in REDIRECT, so lu is ignored there.
         st_d          = STALL_LU;
         bub_d         = BUB_LOAD;
         hz.pc_write   = 1'b0;
         hz.ifid_write = 1'b0;
         hz.idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q   <= RUN;
         bub_q  <= '0;
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         bub_q  <= bub_d;
         wait_q <= wait_d;
         if (tmo) err_q <= 1'b1;
      end
   end

   assign hz.state     = st_q;
   assign hz.mem_error = err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!hz.pc_write && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
         if (hz.exmem_flush && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign hz.stall_count = stall_q;
   assign hz.flush_count = flush_q;
`else
   assign hz.stall_count = '0;
   assign hz.flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (LU_BUBBLES=1, MEM_TIMEOUT=4).
module tb_pipeline_hazard_controller;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   pipeline_hazard_controller_if #(.CNT_W(32)) hz ();

   pipeline_hazard_controller #(
      .LU_BUBBLES(1), .MEM_TIMEOUT(4), .CNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .hz(hz)
   );

   always #5 clk = ~clk;

   // {pc_write, pc_src_sel, ifid_write, ifid_flush, idex_write, idex_flush,
   //  exmem_write, exmem_flush, memwb_bubble}
   localparam logic [9:0] RUN_V = 10'b1_00_1_0_1_0_1_0_0;
   localparam logic [9:0] LU_V  = 10'b0_00_0_0_1_1_1_0_0;
   localparam logic [9:0] MW_V  = 10'b0_00_0_0_0_0_0_0_1;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [31:0] EXP_STALL = 32'd1;
   localparam logic [31:0] EXP_FLUSH = 32'd1;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
   localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

   function automatic logic [9:0] rd_v(input logic [1:0] sel);
      return {1'b1, sel, 7'b1_1_1_1_1_1_0};
   endfunction

   function automatic logic [9:0] ctl();
      return {hz.pc_write, hz.pc_src_sel, hz.ifid_write, hz.ifid_flush, hz.idex_write,
              hz.idex_flush, hz.exmem_write, hz.exmem_flush, hz.memwb_bubble};
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mrd, input logic [4:0] wr, input logic br,
                      input logic jp, input logic jr, input logic ma, input logic rdy);
      hz.id_rs              = rs;
      hz.id_rt              = rt;
      hz.id_uses_rt         = urt;
      hz.idex_memread       = mrd;
      hz.idex_write_reg     = wr;
      hz.exmem_branch_taken = br;
      hz.exmem_jump         = jp;
      hz.exmem_jr           = jr;
      hz.exmem_mem_access   = ma;
      hz.mem_ready          = rdy;
   endtask

   // Drive one cycle's inputs after the falling edge and let them settle.
   task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mrd, input logic [4:0] wr, input logic br,
                      input logic jp, input logic jr, input logic ma, input logic rdy);
      @(negedge clk);
      set(rs, rt, urt, mrd, wr, br, jp, jr, ma, rdy);
      #1;
   endtask

   task automatic idle();
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // Reset held with hazards present: outputs must stay at defaults.
      set(5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #3;
      chk("rst_ctl",   32'(ctl()), 32'(RUN_V));
      chk("rst_state", 32'(hz.state), 32'd0);
      chk("rst_err",   32'(hz.mem_error), 32'd0);
      chk("rst_stall", hz.stall_count, 32'd0);
      chk("rst_flush", hz.flush_count, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      set(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      chk("idle_ctl", 32'(ctl()), 32'(RUN_V));

      // Load-use on rs: one bubble, STALL_LU for one cycle, then RUN.
      cyc(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lu_ctl",   32'(ctl()), 32'(LU_V));
      chk("lu_st0",   32'(hz.state), 32'd0);
      idle();
      chk("lu_rel",   32'(ctl()), 32'(RUN_V));
      chk("lu_st1",   32'(hz.state), 32'd1);
      idle();
      chk("lu_st2",   32'(hz.state), 32'd0);

      // Redirect with branch+jr: JR target wins; lu during REDIRECT is masked.
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("rd_jr_ctl", 32'(ctl()), 32'(rd_v(2'b11)));
      chk("rd_jr_st0", 32'(hz.state), 32'd0);
      cyc(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rd_mask",   32'(ctl()), 32'(RUN_V));
      chk("rd_jr_st1", 32'(hz.state), 32'd3);
      idle();
      chk("rd_jr_st2", 32'(hz.state), 32'd0);
      chk("perf_stall", hz.stall_count, EXP_STALL);
      chk("perf_flush", hz.flush_count, EXP_FLUSH);

      // Jump beats branch; branch alone selects 01.
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rd_jump",   32'(ctl()), 32'(rd_v(2'b10)));
      idle();
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rd_branch", 32'(ctl()), 32'(rd_v(2'b01)));
      idle();
      idle();

      // No stall: $zero destination, or rt match when rt is not read.
      cyc(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lu_zero", 32'(ctl()), 32'(RUN_V));
      cyc(5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lu_nort", 32'(ctl()), 32'(RUN_V));
      chk("lu_nost", 32'(hz.state), 32'd0);
      cyc(5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lu_rt",   32'(ctl()), 32'(LU_V));
      idle();
      idle();

      // Three wait cycles, release on the fourth.
      for (int i = 0; i < 3; i++) begin
         cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("mw_ctl%0d", i), 32'(ctl()), 32'(MW_V));
         chk($sformatf("mw_st%0d", i), 32'(hz.state), (i == 0) ? 32'd0 : 32'd2);
      end
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("mw_rel",    32'(ctl()), 32'(RUN_V));
      chk("mw_rel_st", 32'(hz.state), 32'd2);
      idle();
      chk("mw_done",   32'(hz.state), 32'd0);
      chk("mw_noerr",  32'(hz.mem_error), 32'd0);

      // Load-use pending under a wait is taken in the release cycle.
      cyc(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("mwlu_wait", 32'(ctl()), 32'(MW_V));
      cyc(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("mwlu_rel",  32'(ctl()), 32'(LU_V));
      idle();
      chk("mwlu_st",   32'(hz.state), 32'd1);
      idle();

      // Timeout: four wait cycles, forced release, sticky error.
      for (int i = 0; i < 4; i++) begin
         cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("to_wait%0d", i), 32'(ctl()), 32'(MW_V));
      end
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("to_rel",    32'(ctl()), 32'(RUN_V));
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("to_err",    32'(hz.mem_error), 32'd1);
      chk("to_rewait", 32'(ctl()), 32'(MW_V));
      chk("to_st",     32'(hz.state), 32'd0);
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("to_sticky", 32'(hz.mem_error), 32'd1);
      chk("to_st2",    32'(hz.state), 32'd2);

      // Reset pulse in the middle of the stall.
      reset = 1'b0;
      #1;
      chk("rp_state", 32'(hz.state), 32'd0);
      chk("rp_err",   32'(hz.mem_error), 32'd0);
      chk("rp_ctl",   32'(ctl()), 32'(RUN_V));
      @(negedge clk);
      reset = 1'b1;
      set(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      chk("rp_after", 32'(hz.state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
